apb_arbiter: RTL and testbench



---
 rtl/apb_arbiter_if.sv | 29 ++
 rtl/apb_arbiter.sv | 134 +++++++++++++
 tb/tb_apb_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_arbiter_if.sv
// rtl/apb_arbiter_if.sv - APB bus bundle, NoPorts wide, for the arbiter's upstream (slave) and downstream (master) sides
interface apb_arbiter_if #(
    parameter int unsigned NoPorts   = 1,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic [NoPorts-1:0][AddrWidth-1:0] paddr;
    logic [NoPorts-1:0][2:0]           pprot;
    logic [NoPorts-1:0]                psel;
    logic [NoPorts-1:0]                penable;
    logic [NoPorts-1:0]                pwrite;
    logic [NoPorts-1:0][DataWidth-1:0] pwdata;
    logic [NoPorts-1:0][StrbWidth-1:0] pstrb;
    logic [NoPorts-1:0]                pready;
    logic [NoPorts-1:0][DataWidth-1:0] prdata;
    logic [NoPorts-1:0]                pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - N-to-1 APB arbiter, one transfer in flight; APB_ARBITER_RR_EN selects round-robin over fixed priority
module apb_arbiter #(
    parameter int unsigned NoSlvPorts = 4,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32
) (
    input logic           clk_i,
    input logic           rst_i,
    apb_arbiter_if.slave  slv,
    apb_arbiter_if.master mst
);
    localparam int unsigned IdxWidth = $clog2(NoSlvPorts);

    typedef logic [IdxWidth-1:0] idx_t;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e state_q, state_d;
    idx_t   grant_q, grant_d;
    idx_t   winner;
    logic   found;
    logic   complete;
    logic   unused_penable;

    // Grant is decided on PSEL alone; PENABLE carries no information the arbiter needs.
    assign unused_penable = ^slv.penable;

`ifdef APB_ARBITER_RR_EN
    idx_t rr_ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else if (complete) begin
            rr_ptr_q <= (grant_q == idx_t'(NoSlvPorts - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    // Scan from the pointer, wrapping N-1 -> 0, so the last winner moves to the back.
    always_comb begin
        int j;
        winner = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < int'(NoSlvPorts); k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= int'(NoSlvPorts)) begin
                j = j - int'(NoSlvPorts);
            end
            if (!found && slv.psel[idx_t'(j)]) begin
                winner = idx_t'(j);
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < int'(NoSlvPorts); k++) begin
            if (!found && slv.psel[idx_t'(k)]) begin
                winner = idx_t'(k);
                found  = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|slv.psel) begin
                    grant_d = winner;
                    state_d = SETUP;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (mst.pready[0]) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mst.paddr   = '0;
        mst.pprot   = '0;
        mst.psel    = '0;
        mst.penable = '0;
        mst.pwrite  = '0;
        mst.pwdata  = '0;
        mst.pstrb   = '0;
        if (state_q != IDLE) begin
            mst.paddr[0]   = slv.paddr[grant_q];
            mst.pprot[0]   = slv.pprot[grant_q];
            mst.psel[0]    = 1'b1;
            mst.penable[0] = (state_q == ACCESS);
            mst.pwrite[0]  = slv.pwrite[grant_q];
            mst.pwdata[0]  = slv.pwdata[grant_q];
            mst.pstrb[0]   = slv.pstrb[grant_q];
        end
    end

    // A response to an initiator that already let go of PSEL is dropped, as is one racing a reset.
    always_comb begin
        slv.pready  = '0;
        slv.prdata  = '0;
        slv.pslverr = '0;
        if (complete && !rst_i && slv.psel[grant_q]) begin
            slv.pready[grant_q]  = 1'b1;
            slv.prdata[grant_q]  = mst.prdata[0];
            slv.pslverr[grant_q] = mst.pslverr[0];
        end
    end

    granted_psel_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != IDLE) |-> slv.psel[grant_q]);

endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - scoreboard bench for apb_arbiter with a transaction-level arbitration model
module tb_apb_arbiter;
    localparam int N  = 5;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int NEVER = 32'h3fff_ffff;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [2:0]    prot;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
    } req_t;
    typedef struct { int waits; logic [DW-1:0] rdata; logic err; } rsp_t;
    typedef struct { int setup_cyc; int end_cyc; req_t req; } dn_t;
    typedef struct { int cyc; int port; logic [DW-1:0] rdata; logic err; } up_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_arbiter_if #(.NoPorts(N), .AddrWidth(AW), .DataWidth(DW)) slv ();
    apb_arbiter_if #(.NoPorts(1), .AddrWidth(AW), .DataWidth(DW)) mst ();

    apb_arbiter #(.NoSlvPorts(N), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .slv   (slv),
        .mst   (mst)
    );

    req_t req_script [N][$];
    rsp_t rsp_script [$];
    dn_t  exp_dn [$];
    up_t  exp_up [$];

    bit   m_active [N];
    int   m_start [N];
    int   m_done [N];
    req_t m_req [N];
    int   free_at = 0;
    int   rr = 0;
    int   sched_setup = -10;
    int   sched_c = -10;
    logic [DW-1:0] sched_rdata;
    logic sched_err;
    bit   rand_en = 1'b0;
    int   xfers = 0;

    function automatic void chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    // Arbitration rule from the specification: first requester at or after the pointer (RR) or lowest index.
    function automatic int pick(input bit [N-1:0] req, input int ptr);
        int start = 0;
`ifdef APB_ARBITER_RR_EN
        start = ptr;
`endif
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.write = 1'($urandom_range(0, 1));
        r.addr  = $urandom;
        r.prot  = 3'($urandom_range(0, 7));
        r.wdata = $urandom;
        r.strb  = 4'($urandom_range(0, 15));
        return r;
    endfunction

    function automatic req_t mk_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_t r;
        r.write = w; r.addr = a; r.prot = 3'b000; r.wdata = d; r.strb = s;
        return r;
    endfunction

    function automatic rsp_t mk_rsp(input int w, input logic [DW-1:0] d, input logic e);
        rsp_t r;
        r.waits = w; r.rdata = d; r.err = e;
        return r;
    endfunction

    task automatic step(input bit reset_now);
        bit [N-1:0] reqv;
        int   t;
        int   win;
        rsp_t rs;
        dn_t  d;
        up_t  u;
        @(posedge clk);
        #1;
        t   = cyc;
        rst = reset_now;
        for (int p = 0; p < N; p++) begin
            if (m_active[p] && m_done[p] == t - 1) m_active[p] = 1'b0;
            if (!m_active[p]) begin
                if (req_script[p].size() > 0) begin
                    m_req[p] = req_script[p].pop_front();
                    m_active[p] = 1'b1; m_start[p] = t; m_done[p] = NEVER;
                end else if (rand_en && $urandom_range(0, 3) == 0) begin
                    m_req[p] = rand_req();
                    m_active[p] = 1'b1; m_start[p] = t; m_done[p] = NEVER;
                end
            end
            reqv[p]            = m_active[p];
            slv.psel[p]        = m_active[p];
            slv.penable[p]     = m_active[p] && (t > m_start[p]);
            if (m_active[p]) begin
                slv.pwrite[p] = m_req[p].write; slv.paddr[p] = m_req[p].addr;
                slv.pprot[p]  = m_req[p].prot;  slv.pwdata[p] = m_req[p].wdata;
                slv.pstrb[p]  = m_req[p].strb;
            end else begin
                slv.pwrite[p] = 1'($urandom); slv.paddr[p] = $urandom; slv.pprot[p] = 3'($urandom);
                slv.pwdata[p] = $urandom;     slv.pstrb[p] = 4'($urandom);
            end
        end
        // Transaction-level model: when free, grant; SETUP next cycle; completion after the chosen waits.
        if (!reset_now && t >= free_at && reqv != '0) begin
            win = pick(reqv, rr);
            rs  = (rsp_script.size() > 0) ? rsp_script.pop_front()
                                          : mk_rsp($urandom_range(0, 3), $urandom, 1'($urandom));
            sched_setup = t + 1;
            sched_c     = t + 2 + rs.waits;
            sched_rdata = rs.rdata;
            sched_err   = rs.err;
            d.setup_cyc = t + 1; d.end_cyc = sched_c; d.req = m_req[win];
            exp_dn.push_back(d);
            u.cyc = sched_c; u.port = win; u.rdata = rs.rdata; u.err = rs.err;
            exp_up.push_back(u);
            m_done[win] = sched_c;
            free_at = sched_c + 1;
            rr = (win + 1) % N;
            xfers++;
        end
        if (reset_now) begin
            mst.pready[0] = 1'b0; mst.prdata[0] = $urandom; mst.pslverr[0] = 1'b0;
        end else if (t == sched_c) begin
            mst.pready[0] = 1'b1; mst.prdata[0] = sched_rdata; mst.pslverr[0] = sched_err;
        end else if (t > sched_setup && t < sched_c) begin
            mst.pready[0] = 1'b0; mst.prdata[0] = $urandom; mst.pslverr[0] = 1'($urandom);
        end else begin
            mst.pready[0] = 1'($urandom); mst.prdata[0] = $urandom; mst.pslverr[0] = 1'($urandom);
        end
        if (reset_now) begin
            for (int p = 0; p < N; p++) m_active[p] = 1'b0;
            exp_up.delete();
            while (exp_dn.size() > 0 && exp_dn[$].setup_cyc > t) void'(exp_dn.pop_back());
            if (exp_dn.size() > 0 && exp_dn[0].end_cyc > t) exp_dn[0].end_cyc = t;
            free_at = t + 1; rr = 0; sched_setup = -10; sched_c = -10;
        end
    endtask

    always @(negedge clk) begin
        dn_t d;
        up_t u;
        logic [N-1:0][DW-1:0] e_rd;
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_err;
        if (cyc >= 1) begin
            if (exp_dn.size() > 0 && exp_dn[0].setup_cyc <= cyc) begin
                d = exp_dn[0];
                chk(mst.psel[0] == 1'b1, "dn_psel", 256'(mst.psel), 256'(1));
                chk(mst.penable[0] == (cyc != d.setup_cyc), "dn_penable", 256'(mst.penable), 256'(cyc != d.setup_cyc));
                chk({mst.pwrite[0], mst.paddr[0], mst.pprot[0], mst.pwdata[0], mst.pstrb[0]} ==
                    {d.req.write, d.req.addr, d.req.prot, d.req.wdata, d.req.strb}, "dn_fields",
                    256'({mst.pwrite[0], mst.paddr[0], mst.pprot[0], mst.pwdata[0], mst.pstrb[0]}),
                    256'({d.req.write, d.req.addr, d.req.prot, d.req.wdata, d.req.strb}));
                if (cyc == d.end_cyc) void'(exp_dn.pop_front());
            end else begin
                chk({mst.psel, mst.penable, mst.pwrite, mst.paddr, mst.pprot, mst.pwdata, mst.pstrb} == '0, "dn_idle",
                    256'({mst.psel, mst.penable, mst.pwrite, mst.paddr, mst.pprot, mst.pwdata, mst.pstrb}), 256'(0));
            end
            e_rd = '0; e_rdy = '0; e_err = '0;
            if (exp_up.size() > 0 && exp_up[0].cyc == cyc) begin
                u = exp_up.pop_front();
                e_rdy[u.port] = 1'b1; e_rd[u.port] = u.rdata; e_err[u.port] = u.err;
            end
            chk(slv.pready == e_rdy, "up_pready", 256'(slv.pready), 256'(e_rdy));
            chk(slv.prdata == e_rd, "up_prdata", 256'(slv.prdata), 256'(e_rd));
            chk(slv.pslverr == e_err, "up_pslverr", 256'(slv.pslverr), 256'(e_err));
        end
    end

    initial begin
        int base;
        int guard;
        slv.psel = '0; slv.penable = '0; slv.pwrite = '0; slv.paddr = '0;
        slv.pprot = '0; slv.pwdata = '0; slv.pstrb = '0;
        mst.pready = '0; mst.prdata = '0; mst.pslverr = '0;
        for (int p = 0; p < N; p++) begin
            m_active[p] = 1'b0; m_start[p] = 0; m_done[p] = NEVER;
        end
        step(1'b1);
        step(1'b1);
        repeat (2) step(1'b0);

        // Single write from port 1, zero-wait target.
        req_script[1].push_back(mk_req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF));
        rsp_script.push_back(mk_rsp(0, 32'h0, 1'b0));
        repeat (6) step(1'b0);

        // Read from port 2 with three wait states and an error response.
        req_script[2].push_back(mk_req(1'b0, 32'h0000_0100, 32'h0, 4'h0));
        rsp_script.push_back(mk_rsp(3, 32'h1234_5678, 1'b1));
        repeat (9) step(1'b0);

        // Ports 0..3 request back to back; grant order follows the configured policy.
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 4; p++) begin
                req_script[p].push_back(mk_req(1'b1, 32'((p << 8) | k), 32'(p * 16 + k), 4'hF));
                rsp_script.push_back(mk_rsp(0, 32'(32'hA000 + p), 1'b0));
            end
        repeat (30) step(1'b0);

        // Reset in ACCESS with the target stalling, then two simultaneous requesters.
        req_script[2].push_back(mk_req(1'b1, 32'h0000_0200, 32'h5555_AAAA, 4'h3));
        rsp_script.push_back(mk_rsp(6, 32'h0, 1'b0));
        repeat (4) step(1'b0);
        step(1'b1);
        req_script[3].push_back(mk_req(1'b0, 32'h0000_0300, 32'h0, 4'h0));
        req_script[0].push_back(mk_req(1'b0, 32'h0000_0000, 32'h0, 4'h0));
        repeat (16) step(1'b0);

        // Randomised traffic from all five ports.
        base = xfers;
        guard = 0;
        rand_en = 1'b1;
        while (xfers < base + 1000 && guard < 20000) begin
            step(1'b0);
            guard++;
        end
        rand_en = 1'b0;
        repeat (40) step(1'b0);
        chk(xfers >= base + 1000, "rand_budget", 256'(xfers - base), 256'(1000));
        chk(exp_dn.size() == 0 && exp_up.size() == 0, "drain",
            256'({exp_dn.size(), exp_up.size()}), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
